request_encoder: RTL and testbench
==================================

# request_encoder

Converts four single-bit request lines into a stream of 2-bit index codes over a valid/ready handshake. It is the inverse of the 2-to-4 decoder: where the decoder fans a 2-bit code out to four strobes, this block collects four strobes and serialises them back into 2-bit codes. Requests are latched in a pending register and served round-robin, so none are lost under backpressure. Repeat requests that arrive while the same index is still pending are counted as drops. It sits between the per-quadrant cell-update logic and the shared update bus.

## Interface
- DROP_CNT_W, default 8: width of the saturating dropped-request counter (minimum 1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all state; wins over every other input in that cycle.
- req_00, req_01, req_10, req_11  in  1 each  request strobes, level-sampled every cycle; index = suffix.
- code_out  out  2  index being offered; registered.
- code_valid  out  1  code_out is valid; registered.
- code_ready  in  1  consumer accepts code_out this cycle when code_valid=1.
- pending  out  4  latched, not-yet-issued requests; bit i = index i.
- busy  out  1  code_valid | (|pending); combinational from registers.
- drop_count  out  DROP_CNT_W  saturating count of redundant requests.

## Operation
- State registers: pending[3:0], ptr[1:0] (round-robin start), code_out, code_valid, drop_count.
- Reset values (rst_n=0, immediate): pending=0, ptr=0, code_out=2'b00, code_valid=0, drop_count=0; busy=0.
- Slot free = !code_valid | code_ready.
- Selection, when the slot is free and pending!=0:
  - Search pending in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set index k wins.
  - code_out<=k, code_valid<=1, pending[k] cleared, ptr<=k+1 (mod 4; wraps 3->0).
- Slot free and pending==0: code_valid<=0; code_out holds its last value.
- Slot not free (code_valid=1, code_ready=0): code_out, code_valid and ptr hold; pending only accumulates.
- Selection uses the pending value from before this cycle's requests, so a request cannot be issued in the cycle it arrives.
- Request capture, for each i with req_i=1:
  - pending[i] already 0, or pending[i] being issued this cycle: pending[i]<=1, no drop.
  - pending[i]=1 and not being issued this cycle: drop_count += 1, saturating at 2^DROP_CNT_W-1.
  - Several drops in one cycle add their count (0-4), saturating.
- clear=1: pending<=0, code_valid<=0, ptr<=0, drop_count<=0; requests and the handshake in that cycle are ignored.
- rst_n may assert at any time. The block returns asynchronously to reset values, and any in-flight code is discarded.

## Timing
- Latency: req_i high in cycle N -> pending[i]=1 in cycle N+1 -> code_valid=1 with code_out=i in cycle N+2, provided the slot is free in N+1 and no other pending index precedes i.
- Throughput: one code per cycle while code_ready=1 and pending!=0.
- Handshake: transfer occurs on a clock edge where code_valid=1 and code_ready=1. Once code_valid rises, code_out stays stable until that transfer.
- code_valid never drops without a transfer, except on clear or reset.
- drop_count updates one cycle after the offending request.

## Test plan
- Single request: reset, req_10=1 for one cycle, code_ready=1.
  - Required: pending=4'b0100 the next cycle, then code_valid=1 with code_out=2'b10 for exactly one cycle, then busy=0.
- All four at once: all req=1 for one cycle, code_ready=1.
  - Required: code_out 00,01,10,11 on four consecutive valid cycles; ptr wraps to 0; drop_count=0.
- Backpressure: as the all-four case but code_ready=0 for 5 cycles.
  - Required: code_out=00 held with code_valid=1 and pending=4'b1110 throughout; sequence completes after code_ready rises.
- Fairness: hold req_00 and req_11 high continuously, code_ready=1.
  - Required: codes alternate 00,11,00,11…
  - Required: drop_count increments each cycle that the held index is pending but not issued.
- Saturation: with DROP_CNT_W=2, hold code_ready=0 and pulse req_01 six times.
  - Required: drop_count reaches 3 and stays at 3.
  - Required: clear then returns drop_count=0, pending=0, code_valid=0.
- Reset mid-operation: assert rst_n=0 asynchronously while code_valid=1 and pending=4'b1010.
  - Required: all outputs at reset values before the next clock edge; no code issued after release until a new request.

Source files
------------

// File: rtl/request_encoder.sv
// request_encoder
//   Collects four single-bit request strobes into a pending register and
//   serialises them as 2-bit index codes over a valid/ready handshake.
//   Pending requests are served round-robin starting at ptr. A request that
//   arrives while its index is already pending (and not leaving this cycle)
//   is counted in a saturating drop counter.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              synchronous clear of all state, highest priority
//   req_00..req_11     request strobes, level-sampled; index = suffix
//   code_out           index being offered (registered)
//   code_valid         code_out is valid (registered)
//   code_ready         consumer accepts code_out when code_valid=1
//   pending            latched, not-yet-issued requests, bit i = index i
//   busy               code_valid | (|pending)
//   drop_count         saturating count of redundant requests
module request_encoder #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  req_00,
  input  logic                  req_01,
  input  logic                  req_10,
  input  logic                  req_11,
  output logic [1:0]            code_out,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [3:0]            pending,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int NUM_LANES = 4;
  localparam logic [DROP_CNT_W+2:0] DROP_MAX = {3'b000, {DROP_CNT_W{1'b1}}};

  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] issue;
  logic [NUM_LANES-1:0] drop;
  logic [1:0]           ptr;
  logic                 slot_free;
  logic                 sel_found;
  logic [1:0]           sel_idx;
  logic [1:0]           probe;
  logic [2:0]           n_drop;
  logic [DROP_CNT_W+2:0] drop_sum;
  logic [DROP_CNT_W-1:0] drop_nxt;

  assign req       = {req_11, req_10, req_01, req_00};
  assign slot_free = !code_valid || code_ready;
  assign busy      = code_valid || (|pending);

  // Round-robin search from ptr. Walking offsets high-to-low lets the
  // smallest offset (closest to ptr) overwrite and win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    probe     = ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      probe = ptr + 2'(i);
      if (pending[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  assign issue = (slot_free && sel_found) ? (NUM_LANES'(1) << sel_idx) : '0;

  // Per-lane pending bit. Selection looks at the pre-request pending value,
  // so a lane being issued this cycle can re-arm from its request without
  // counting a drop.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign drop[g] = req[g] && pending[g] && !issue[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     pending[g] <= 1'b0;
      else if (clear) pending[g] <= 1'b0;
      else            pending[g] <= (pending[g] && !issue[g]) || req[g];
    end
  end

  // Up to four drops per cycle, added with saturation.
  always_comb begin
    n_drop = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) n_drop = n_drop + {2'b00, drop[i]};
    drop_sum = {3'b000, drop_count} + {{DROP_CNT_W{1'b0}}, n_drop};
    drop_nxt = (drop_sum > DROP_MAX) ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out   <= 2'b00;
      code_valid <= 1'b0;
      ptr        <= 2'b00;
      drop_count <= '0;
    end else if (clear) begin
      code_valid <= 1'b0;
      ptr        <= 2'b00;
      drop_count <= '0;
    end else begin
      if (slot_free) begin
        if (sel_found) begin
          code_out   <= sel_idx;
          code_valid <= 1'b1;
          ptr        <= sel_idx + 2'd1;
        end else begin
          code_valid <= 1'b0;
        end
      end
      drop_count <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_request_encoder.sv
// Scoreboard bench for request_encoder: stimulus pushes the expected codes,
// a negedge monitor pops and compares on every handshake transfer.
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n, clear, code_ready;
  logic       req_00, req_01, req_10, req_11;
  logic [1:0] code_out;
  logic       code_valid, busy;
  logic [3:0] pending;
  logic [1:0] drop_count;

  int vectors    = 0;
  int miscompares = 0;
  int exp_q[$];

  request_encoder #(.DROP_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_00(req_00), .req_01(req_01), .req_10(req_10), .req_11(req_11),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .pending(pending), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 30) begin
      tick;
      n++;
    end
    chk({name, " drained"}, 32'(busy), 0);
  endtask

  // Monitor: every transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected code: got %0d expected none", code_out);
      end else begin
        chk("code_out", 32'(code_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; code_ready = 1'b0;
    req_00 = 1'b0; req_01 = 1'b0; req_10 = 1'b0; req_11 = 1'b0;
    #2;
    chk("reset code_valid", 32'(code_valid), 0);
    chk("reset code_out", 32'(code_out), 0);
    chk("reset pending", 32'(pending), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset drop_count", 32'(drop_count), 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Single request
    code_ready = 1'b1;
    do_clear;
    req_10 = 1'b1; exp_q.push_back(2);
    tick; req_10 = 1'b0;
    chk("single pending", 32'(pending), 4'b0100);
    chk("single valid early", 32'(code_valid), 0);
    tick;
    chk("single valid", 32'(code_valid), 1);
    chk("single code", 32'(code_out), 2);
    tick;
    chk("single valid after", 32'(code_valid), 0);
    chk("single busy after", 32'(busy), 0);

    // All four at once
    do_clear;
    {req_11, req_10, req_01, req_00} = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick; {req_11, req_10, req_01, req_00} = 4'b0000;
    chk("all pending", 32'(pending), 4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("all valid", 32'(code_valid), 1);
      chk("all code", 32'(code_out), 32'(i));
    end
    chk("all ptr wrap", 32'(dut.ptr), 0);
    tick;
    chk("all done valid", 32'(code_valid), 0);
    chk("all drop_count", 32'(drop_count), 0);

    // Backpressure
    code_ready = 1'b0;
    do_clear;
    {req_11, req_10, req_01, req_00} = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick; {req_11, req_10, req_01, req_00} = 4'b0000;
    chk("bp pending", 32'(pending), 4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp valid", 32'(code_valid), 1);
      chk("bp code held", 32'(code_out), 0);
      chk("bp pending held", 32'(pending), 4'b1110);
    end
    code_ready = 1'b1;
    drain("bp");
    chk("bp drop_count", 32'(drop_count), 0);

    // Fairness: 00 and 11 held for six sampled cycles
    do_clear;
    req_00 = 1'b1; req_11 = 1'b1;
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
    tick;
    chk("fair pending", 32'(pending), 4'b1001);
    chk("fair drop 0", 32'(drop_count), 0);
    tick;
    chk("fair code 0", 32'(code_out), 0);
    chk("fair drop 1", 32'(drop_count), 1);
    tick;
    chk("fair code 3", 32'(code_out), 3);
    chk("fair drop 2", 32'(drop_count), 2);
    tick;
    chk("fair drop 3", 32'(drop_count), 3);
    tick; tick;
    req_00 = 1'b0; req_11 = 1'b0;
    drain("fair");

    // Saturation with a 2-bit counter
    code_ready = 1'b0;
    do_clear;
    for (int p = 0; p < 6; p++) begin
      req_01 = 1'b1;
      tick;
      req_01 = 1'b0;
      chk("sat drop", 32'(drop_count), (p < 2) ? 0 : ((p - 1 > 3) ? 3 : p - 1));
      tick;
    end
    chk("sat code held", 32'(code_out), 1);
    chk("sat pending", 32'(pending), 4'b0010);
    tick; tick;
    chk("sat drop stays", 32'(drop_count), 3);
    do_clear;
    chk("clear drop", 32'(drop_count), 0);
    chk("clear pending", 32'(pending), 0);
    chk("clear valid", 32'(code_valid), 0);

    // Asynchronous reset mid-operation
    do_clear;
    req_00 = 1'b1; req_01 = 1'b1; req_11 = 1'b1;
    tick;
    req_00 = 1'b0; req_01 = 1'b0; req_11 = 1'b0;
    tick;
    chk("mid valid", 32'(code_valid), 1);
    chk("mid pending", 32'(pending), 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("async code_valid", 32'(code_valid), 0);
    chk("async code_out", 32'(code_out), 0);
    chk("async pending", 32'(pending), 0);
    chk("async busy", 32'(busy), 0);
    chk("async drop_count", 32'(drop_count), 0);
    tick; tick;
    #3 rst_n = 1'b1;
    code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post reset idle", 32'(code_valid), 0);
      chk("post reset busy", 32'(busy), 0);
    end
    req_11 = 1'b1; exp_q.push_back(3);
    tick; req_11 = 1'b0;
    tick;
    chk("post reset code valid", 32'(code_valid), 1);
    chk("post reset code", 32'(code_out), 3);
    tick;
    chk("post reset done", 32'(code_valid), 0);

    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
